// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access types, error-capture FSM states and the error-record layout.
package rv_iopmp_pkg;

   typedef enum logic [1:0] {
      ACC_NONE  = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2,
      ACC_EXEC  = 2'd3
   } access_t;

   localparam int unsigned TTYPE_W    = 2;
   localparam int unsigned ETYPE_W    = 3;
   localparam int unsigned EID_W      = 16;
   // Record fields are sized for the widest supported address / source ID
   localparam int unsigned REC_ADDR_W = 64;
   localparam int unsigned REC_SID_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } err_state_e;

   typedef struct packed {
      logic [TTYPE_W-1:0]    ttype;
      logic [ETYPE_W-1:0]    etype;
      logic [REC_ADDR_W-1:0] addr;
      logic [REC_SID_W-1:0]  sid;
      logic [EID_W-1:0]      eid;
   } err_record_t;

   function automatic logic [TTYPE_W-1:0] ttype_of(input access_t acc);
      return TTYPE_W'(acc);
   endfunction

endpackage

// File: rtl/rv_iopmp_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module rv_iopmp_sat_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_cnt;

   // Count register: clear, else increment until saturated
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= {WIDTH{1'b0}};
      end else if (clr_i) begin
         r_cnt <= {WIDTH{1'b0}};
      end else if (inc_i && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-record capture: latches the first illegal access until software clears it.
// Optional missed-error counter enabled by macro RV_IOPMP_ERR_CNT_EN.
module rv_iopmp_err_capture
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned SID_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [SID_WIDTH-1:0]  sid_i,
   input  access_t               access_type_i,
   input  logic                  err_transaction_i,
   input  logic [2:0]            err_type_i,
   input  logic [15:0]           err_entry_index_i,
   input  logic                  ie_i,
   input  logic                  ip_clr_i,
   output logic                  err_ip_o,
   output logic [1:0]            err_ttype_o,
   output logic [2:0]            err_etype_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic [SID_WIDTH-1:0]  err_sid_o,
   output logic [15:0]           err_eid_o,
   output logic                  irq_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o
);

   err_state_e  r_state;
   err_record_t r_rec;
   err_record_t w_rec_new;
   logic        w_evt;
   logic        w_load;

   assign w_evt  = req_valid_i & err_transaction_i;
   // A clear in the same cycle as an event lets the new event take the record
   assign w_load = w_evt & ((r_state == IDLE) | ip_clr_i);

   assign w_rec_new.ttype = ttype_of(access_type_i);
   assign w_rec_new.etype = err_type_i;
   assign w_rec_new.addr  = REC_ADDR_W'(addr_i);
   assign w_rec_new.sid   = REC_SID_W'(sid_i);
   assign w_rec_new.eid   = err_entry_index_i;

   // Record-valid FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    r_state <= w_evt ? HELD : IDLE;
            HELD:    r_state <= (ip_clr_i && !w_evt) ? IDLE : HELD;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Sticky record; stale contents are kept after a clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rec <= '0;
      end else if (w_load) begin
         r_rec <= w_rec_new;
      end else begin
         r_rec <= r_rec;
      end
   end

   assign err_ip_o    = (r_state == HELD);
   assign irq_o       = err_ip_o & ie_i;
   assign err_ttype_o = r_rec.ttype;
   assign err_etype_o = r_rec.etype;
   assign err_addr_o  = r_rec.addr[ADDR_WIDTH-1:0];
   assign err_sid_o   = r_rec.sid[SID_WIDTH-1:0];
   assign err_eid_o   = r_rec.eid;

`ifdef RV_IOPMP_ERR_CNT_EN
   logic w_missed;

   assign w_missed = w_evt & (r_state == HELD) & ~ip_clr_i;

   rv_iopmp_sat_cnt #(
      .WIDTH (CNT_WIDTH)
   ) u_miss_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (ip_clr_i),
      .inc_i  (w_missed),
      .cnt_o  (err_cnt_o)
   );
`else
   assign err_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Scoreboard bench for rv_iopmp_err_capture: driver pushes reference-model expectations,
// a monitor pops and compares them after each clock edge.
module tb_rv_iopmp_err_capture;
   import rv_iopmp_pkg::*;

`ifdef RV_IOPMP_ERR_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, err_tr, tb_ie, ip_clr;
   logic [63:0] addr;
   logic [7:0]  sid;
   access_t     acc;
   logic [2:0]  etype;
   logic [15:0] eidx;
   logic        o_ip, o_irq;
   logic [1:0]  o_tt;
   logic [2:0]  o_et;
   logic [63:0] o_addr;
   logic [7:0]  o_sid, o_cnt;
   logic [15:0] o_eid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ip;
      logic [1:0]  tt;
      logic [2:0]  et;
      logic [63:0] addr;
      logic [7:0]  sid;
      logic [15:0] eid;
      logic        irq;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: record valid flag, record contents, missed-event count
   bit          m_valid;
   logic [1:0]  m_tt;
   logic [2:0]  m_et;
   logic [63:0] m_addr;
   logic [7:0]  m_sid;
   logic [15:0] m_eid;
   int          m_missed;

   always #5 clk = ~clk;

   rv_iopmp_err_capture #(.SID_WIDTH(8), .ADDR_WIDTH(64), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .addr_i(addr), .sid_i(sid),
      .access_type_i(acc), .err_transaction_i(err_tr), .err_type_i(etype),
      .err_entry_index_i(eidx), .ie_i(tb_ie), .ip_clr_i(ip_clr), .err_ip_o(o_ip),
      .err_ttype_o(o_tt), .err_etype_o(o_et), .err_addr_o(o_addr), .err_sid_o(o_sid),
      .err_eid_o(o_eid), .irq_o(o_irq), .err_cnt_o(o_cnt)
   );

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_valid = 1'b0; m_tt = 2'd0; m_et = 3'd0; m_addr = 64'd0;
      m_sid = 8'd0; m_eid = 16'd0; m_missed = 0;
   endfunction

   task automatic step(input logic v, input logic e, input logic [63:0] a, input logic [7:0] s,
                       input logic [1:0] t, input logic [2:0] et, input logic [15:0] eid,
                       input logic ie, input logic clr);
      exp_t x;
      bit   evt;
      @(negedge clk);
      req_valid = v; err_tr = e; addr = a; sid = s; acc = access_t'(t);
      etype = et; eidx = eid; tb_ie = ie; ip_clr = clr;
      evt = v && e;
      if (clr) m_missed = 0;
      if (evt && (!m_valid || clr)) begin
         m_valid = 1'b1; m_tt = t; m_et = et; m_addr = a; m_sid = s; m_eid = eid;
      end else if (evt) begin
         m_missed = (m_missed >= 255) ? 255 : m_missed + 1;
      end else if (clr) begin
         m_valid = 1'b0;
      end
      x.ip = m_valid; x.tt = m_tt; x.et = m_et; x.addr = m_addr; x.sid = m_sid;
      x.eid = m_eid; x.irq = m_valid && ie;
      x.cnt = CNT_ON ? 8'(m_missed) : 8'd0;
      exp_q.push_back(x);
   endtask

   task automatic idle_step(input logic ie, input logic clr);
      step(1'b0, 1'b0, 64'd0, 8'd0, 2'd0, 3'd0, 16'd0, ie, clr);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   // Monitor: compares registered outputs against the oldest expectation after each edge
   always @(posedge clk) begin
      exp_t x;
      #2;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         cmp("sb_ip",    64'(o_ip),   64'(x.ip));
         cmp("sb_irq",   64'(o_irq),  64'(x.irq));
         cmp("sb_cnt",   64'(o_cnt),  64'(x.cnt));
         if (x.ip) begin
            cmp("sb_ttype", 64'(o_tt),   64'(x.tt));
            cmp("sb_etype", 64'(o_et),   64'(x.et));
            cmp("sb_addr",  o_addr,      x.addr);
            cmp("sb_sid",   64'(o_sid),  64'(x.sid));
            cmp("sb_eid",   64'(o_eid),  64'(x.eid));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int wait_cyc;
      rst_n = 1'b0; req_valid = 1'b0; err_tr = 1'b0; tb_ie = 1'b0; ip_clr = 1'b0;
      addr = 64'd0; sid = 8'd0; acc = ACC_NONE; etype = 3'd0; eidx = 16'd0;
      model_reset();
      #7;
      cmp("rst_ip", 64'(o_ip), 64'd0);
      cmp("rst_addr", o_addr, 64'd0);
      cmp("rst_cnt", 64'(o_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // First event captured one cycle later
      step(1'b1, 1'b1, 64'h8000_1000, 8'd3, 2'd2, 3'd2, 16'd5, 1'b1, 1'b0);
      settle();
      cmp("cap_ip", 64'(o_ip), 64'd1);
      cmp("cap_ttype", 64'(o_tt), 64'd2);
      cmp("cap_addr", o_addr, 64'h8000_1000);
      cmp("cap_sid", 64'(o_sid), 64'd3);
      cmp("cap_eid", 64'(o_eid), 64'd5);
      cmp("cap_irq", 64'(o_irq), 64'd1);

      // Second event while held is missed
      step(1'b1, 1'b1, 64'h4000, 8'd4, 2'd1, 3'd1, 16'd6, 1'b1, 1'b0);
      settle();
      cmp("held_addr", o_addr, 64'h8000_1000);
      cmp("held_cnt", 64'(o_cnt), CNT_ON ? 64'd1 : 64'd0);

      idle_step(1'b1, 1'b1);
      settle();
      cmp("clr_ip", 64'(o_ip), 64'd0);
      cmp("clr_irq", 64'(o_irq), 64'd0);

      step(1'b1, 1'b1, 64'h1234, 8'd1, 2'd3, 3'd4, 16'd7, 1'b1, 1'b0);
      settle();
      cmp("recap_eid", 64'(o_eid), 64'd7);
      cmp("recap_cnt", 64'(o_cnt), 64'd0);

      // Clear and event together: new event wins
      step(1'b1, 1'b1, 64'h5678, 8'd2, 2'd1, 3'd3, 16'd9, 1'b1, 1'b1);
      settle();
      cmp("clrevt_ip", 64'(o_ip), 64'd1);
      cmp("clrevt_eid", 64'(o_eid), 64'd9);
      cmp("clrevt_cnt", 64'(o_cnt), 64'd0);

      // Masked interrupt, then unmask combinationally
      idle_step(1'b0, 1'b1);
      step(1'b1, 1'b1, 64'h9abc, 8'd7, 2'd2, 3'd5, 16'd11, 1'b0, 1'b0);
      settle();
      cmp("mask_ip", 64'(o_ip), 64'd1);
      cmp("mask_irq", 64'(o_irq), 64'd0);
      @(negedge clk);
      tb_ie = 1'b1;
      #1;
      cmp("unmask_irq", 64'(o_irq), 64'd1);

      // Saturation of the missed counter
      for (int i = 0; i < 300; i++)
         step(1'b1, 1'b1, {$urandom, $urandom}, 8'($urandom), 2'($urandom_range(1, 3)),
              3'($urandom), 16'($urandom), 1'b1, 1'b0);
      settle();
      cmp("sat_cnt", 64'(o_cnt), CNT_ON ? 64'd255 : 64'd0);
      cmp("sat_eid", 64'(o_eid), 64'd11);

      // Asynchronous reset mid-operation
      #1;
      rst_n = 1'b0;
      #1;
      cmp("arst_ip", 64'(o_ip), 64'd0);
      cmp("arst_irq", 64'(o_irq), 64'd0);
      cmp("arst_ttype", 64'(o_tt), 64'd0);
      cmp("arst_etype", 64'(o_et), 64'd0);
      cmp("arst_addr", o_addr, 64'd0);
      cmp("arst_sid", 64'(o_sid), 64'd0);
      cmp("arst_eid", 64'(o_eid), 64'd0);
      cmp("arst_cnt", 64'(o_cnt), 64'd0);
      model_reset();
      @(negedge clk);
      req_valid = 1'b0; err_tr = 1'b0; ip_clr = 1'b0;
      rst_n = 1'b1;

      // Error flag without a valid verdict is ignored
      step(1'b0, 1'b1, 64'hdead, 8'd1, 2'd1, 3'd1, 16'd1, 1'b1, 1'b0);
      settle();
      cmp("noval_ip", 64'(o_ip), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
              8'($urandom), 2'($urandom_range(1, 3)), 3'($urandom), 16'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      idle_step(1'b1, 1'b0);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #3;
      cmp("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_iopmp_err_capture.md
# rv_iopmp_err_capture

Error-record stage directly downstream of the IOPMP decision logic. It samples each checked transaction's verdict, latches the first illegal access (type, address, source ID, entry index) into sticky error-record registers, and raises an interrupt. The record stays frozen until software clears it. Outputs feed the register file (ERR_REQINFO / ERR_REQADDR / ERR_REQID) and the platform interrupt controller.

## Interface
- SID_WIDTH, 8, source-ID width
- ADDR_WIDTH, 64, transaction address width
- CNT_WIDTH, 8, width of the missed-error counter (only used under the macro)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  a checked transaction's verdict is present this cycle
- addr_i  in  ADDR_WIDTH  transaction address
- sid_i  in  SID_WIDTH  transaction source ID
- access_type_i  in  rv_iopmp_pkg::access_t  read/write/exec
- err_transaction_i  in  1  decision logic flagged an error
- err_type_i  in  3  decision-logic error type (etype)
- err_entry_index_i  in  16  index of the offending entry
- ie_i  in  1  interrupt enable (ERR_CFG.ie)
- ip_clr_i  in  1  single-cycle pulse, software W1C of ERR_REQINFO.ip
- err_ip_o  out  1  error record valid (sticky)
- err_ttype_o  out  2  recorded access type
- err_etype_o  out  3  recorded error type
- err_addr_o  out  ADDR_WIDTH  recorded address
- err_sid_o  out  SID_WIDTH  recorded source ID
- err_eid_o  out  16  recorded entry index
- irq_o  out  1  interrupt request
- err_cnt_o  out  CNT_WIDTH  missed-error count (macro only)

## Operation
- Error event: req_valid_i && err_transaction_i in the same cycle; err_transaction_i without req_valid_i is ignored.
- Two-state FSM: IDLE (no record) and HELD (record valid). err_ip_o = (state == HELD).
- IDLE + error event -> capture all fields, go to HELD.
- HELD + error event, no clear -> record unchanged. The event counts as missed.
- HELD + ip_clr_i, no event -> go to IDLE. Record fields keep their stale values; software must ignore them.
- HELD + ip_clr_i + error event in the same cycle -> the new event overwrites the record and the state stays HELD. The new event is not counted as missed.
- IDLE + ip_clr_i -> no effect.
- err_ttype_o encoding: rv_iopmp_pkg::access_t cast to 2 bits (1 read, 2 write, 3 exec).
- irq_o = err_ip_o && ie_i, combinational from registered ip. Deasserting ie_i masks the interrupt but leaves the record untouched.

## Timing
- Reset: state IDLE; all outputs 0 (err_ip_o, err_ttype_o, err_etype_o, err_addr_o, err_sid_o, err_eid_o, irq_o, err_cnt_o).
- Capture latency is 1 cycle. An event at edge N is visible on the outputs after edge N; irq_o asserts in that same cycle if ie_i = 1.
- Clear latency is 1 cycle. After a clear pulse, err_ip_o and irq_o drop after the next edge.
- Back-to-back events while IDLE: only the first is captured; the second finds state HELD and counts as missed.
- Reset asserted mid-operation returns to IDLE immediately and asynchronously, and clears the record and counter.
- No backpressure: every cycle carrying req_valid_i is consumed.

## Configuration
- Macro RV_IOPMP_ERR_CNT_EN.
- Defined: err_cnt_o counts missed events, saturating at 2^CNT_WIDTH-1. It resets to 0 on ip_clr_i, including in the cycle where a simultaneous event overwrites the record.
- Undefined: no counter register is built and err_cnt_o is tied to 0.

## Structure
- rv_iopmp_pkg gains:
  - err_state_e (IDLE, HELD)
  - err_record_t (ttype, etype, addr, sid, eid)
  - a TTYPE width constant of 2
- Record storage is a single err_record_t register with a load enable. The FSM and load-enable logic live in this module.
- Natural sub-module: rv_iopmp_sat_cnt, a parameterised saturating counter with clear. It is instantiated only under RV_IOPMP_ERR_CNT_EN.

## Test plan
- Reset, then one event (addr 0x8000_1000, sid 3, write, etype 2, eid 5) -> after 1 cycle: ip=1, ttype=2, addr=0x8000_1000, sid=3, eid=5; irq=1 with ie=1.
- Record held, then a second event (addr 0x4000) -> record still shows 0x8000_1000; err_cnt_o=1 (macro on) or 0 (macro off).
- ip_clr_i pulse -> ip=0 and irq=0 next cycle. A later event (eid 7) is captured and err_cnt_o returns to 0.
- ip_clr_i and a new event (eid 9) in the same cycle -> ip stays 1 and eid=9; err_cnt_o=0.
- ie_i=0 with an event -> ip=1 and irq=0. Raise ie_i -> irq=1 combinationally in the same cycle.
- 300 missed events with CNT_WIDTH=8 -> err_cnt_o saturates at 255. Assert rst_ni mid-sequence -> every output is 0 asynchronously.
